// File: rtl/fetch_pkg.sv
// Shared types, default widths and helpers for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned FETCH_IW = 10;
    localparam int unsigned FETCH_DW = 9;
    localparam int unsigned FETCH_OW = 6;
    localparam int unsigned CNT_W    = 32;

    typedef logic [FETCH_IW-1:0] pc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : CNT_W'(v + CNT_W'(1));
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch controller bus: ROM address/data, decode controls, handshake and status.
interface inst_fetch_ctrl_if #(
    parameter int unsigned IW = 10,
    parameter int unsigned DW = 9,
    parameter int unsigned OW = 6
) ();

    logic          start;
    logic [IW-1:0] inst_addr;
    logic [DW-1:0] inst_in;
    logic [DW-1:0] inst_out;
    logic          inst_valid;
    logic          stall;
    logic          branch_en;
    logic [OW-1:0] branch_off;
    logic          jump_en;
    logic [IW-1:0] jump_target;
    logic          halt_req;
    logic          done;
    logic          timeout;
    logic [31:0]   cycle_count;
    logic [31:0]   inst_count;

    // Fetch controller side.
    modport master (
        input  start, inst_in, stall, branch_en, branch_off,
               jump_en, jump_target, halt_req,
        output inst_addr, inst_out, inst_valid, done, timeout,
               cycle_count, inst_count
    );

    // ROM / decode / launcher side.
    modport slave (
        output start, inst_in, stall, branch_en, branch_off,
               jump_en, jump_target, halt_req,
        input  inst_addr, inst_out, inst_valid, done, timeout,
               cycle_count, inst_count
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: stall/halt hold > jump > relative branch > increment.
module fetch_next_pc #(
    parameter int unsigned IW = 10,
    parameter int unsigned OW = 6
) (
    input  logic [IW-1:0] pc_i,
    input  logic          stall_i,
    input  logic          halt_i,
    input  logic          jump_en_i,
    input  logic [IW-1:0] jump_target_i,
    input  logic          branch_en_i,
    input  logic [OW-1:0] branch_off_i,
    output logic [IW-1:0] pc_next_c
);

    logic [IW-1:0] off_ext;

    // Sign-extend the offset so the addition wraps modulo 2**IW.
    assign off_ext = {{(IW-OW){branch_off_i[OW-1]}}, branch_off_i};

    // Priority mux for the next program counter.
    always_comb begin
        pc_next_c = IW'(pc_i + IW'(1));
        if (stall_i || halt_i) begin
            pc_next_c = pc_i;
        end else if (jump_en_i) begin
            pc_next_c = jump_target_i;
        end else if (branch_en_i) begin
            pc_next_c = IW'(pc_i + off_ext);
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Program sequencer: PC, ROM addressing, start/done handshake, counters, watchdog.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned IW         = FETCH_IW,
    parameter int unsigned DW         = FETCH_DW,
    parameter int unsigned OW         = FETCH_OW,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned MAX_CYCLES = 4096
) (
    input  logic              Clk,
    input  logic              Reset,
    inst_fetch_ctrl_if.master bus
);

    fetch_state_t     state_q, state_d;
    logic [IW-1:0]    pc_q, pc_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;

    logic [IW-1:0]    pc_next_c;
    logic             issue_c;
    logic             wd_hit_c;
    logic [DW-1:0]    inst_c;

    // Instruction is issued whenever RUN is not stalled.
    assign issue_c = (state_q == RUN) && !bus.stall;

    // Watchdog fires on the last allowed RUN cycle.
    assign wd_hit_c = (MAX_CYCLES != 0) && (cyc_q == CNT_W'(MAX_CYCLES - 1));

    fetch_next_pc #(
        .IW (IW),
        .OW (OW)
    ) u_next_pc (
        .pc_i          (pc_q),
        .stall_i       (bus.stall),
        .halt_i        (bus.halt_req),
        .jump_en_i     (bus.jump_en),
        .jump_target_i (bus.jump_target),
        .branch_en_i   (bus.branch_en),
        .branch_off_i  (bus.branch_off),
        .pc_next_c     (pc_next_c)
    );

    // Next-state, PC, counter and status logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        cyc_d     = cyc_q;
        icnt_d    = icnt_q;

        case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_d   = RUN;
                    pc_d      = IW'(START_ADDR);
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    cyc_d     = '0;
                    icnt_d    = '0;
                end
            end
            RUN: begin
                cyc_d = sat_inc(cyc_q);
                if (issue_c) begin
                    icnt_d = sat_inc(icnt_q);
                end
                if (issue_c && bus.halt_req) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end else if (wd_hit_c) begin
                    state_d   = HALT;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    pc_d = pc_next_c;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= IW'(START_ADDR);
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cyc_q     <= '0;
            icnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cyc_q     <= cyc_d;
            icnt_q    <= icnt_d;
        end
    end

    assign inst_c          = bus.inst_in;
    assign bus.inst_out    = inst_c;
    assign bus.inst_addr   = pc_q;
    assign bus.inst_valid  = issue_c;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cyc_q;
    assign bus.inst_count  = icnt_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: directed scenarios plus random control traffic.
module tb_inst_fetch_ctrl;
    import fetch_pkg::*;

    localparam int unsigned MAXC  = 16;
    localparam int unsigned DEPTH = 1024;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct packed {
        logic [9:0]  addr;
        logic        valid;
        logic [8:0]  inst;
        logic        done;
        logic        to;
        logic [31:0] cyc;
        logic [31:0] icnt;
    } exp_t;

    logic Clk;
    logic Reset;
    logic [8:0] rom [DEPTH];

    exp_t exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model of the sequencer.
    int          m_st;
    int unsigned m_pc;
    longint unsigned m_cyc, m_icnt;
    bit          m_done, m_to;

    inst_fetch_ctrl_if #(.IW(10), .DW(9), .OW(6)) bus ();

    inst_fetch_ctrl #(
        .IW(10), .DW(9), .OW(6), .START_ADDR(0), .MAX_CYCLES(MAXC)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    assign bus.inst_in = rom[bus.inst_addr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic longint unsigned sat(input longint unsigned v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_pc = 0; m_cyc = 0; m_icnt = 0; m_done = 0; m_to = 0;
    endtask

    // Drive one cycle of inputs, queue the expected outputs, advance the model.
    task automatic step(input bit rst, input bit st, input bit stl, input bit hr,
                        input bit jp, input int unsigned tgt, input bit br,
                        input logic [5:0] off);
        exp_t e;
        int   o;
        Reset           = rst;
        bus.start       = st;
        bus.stall       = stl;
        bus.halt_req    = hr;
        bus.jump_en     = jp;
        bus.jump_target = 10'(tgt);
        bus.branch_en   = br;
        bus.branch_off  = off;

        e.addr  = 10'(m_pc);
        e.valid = (m_st == M_RUN) && !stl;
        e.inst  = rom[m_pc];
        e.done  = m_done;
        e.to    = m_to;
        e.cyc   = 32'(m_cyc);
        e.icnt  = 32'(m_icnt);
        exp_q.push_back(e);

        if (rst) begin
            model_reset();
        end else if (m_st != M_RUN) begin
            if (st) begin
                m_st = M_RUN; m_pc = 0; m_cyc = 0; m_icnt = 0; m_done = 0; m_to = 0;
            end
        end else begin
            bit last;
            last = (m_cyc + 1 == MAXC);
            m_cyc = sat(m_cyc);
            if (!stl) m_icnt = sat(m_icnt);
            if (!stl && hr) begin
                m_st = M_HALT; m_done = 1;
            end else if (last) begin
                m_st = M_HALT; m_done = 1; m_to = 1;
            end else if (!stl) begin
                o = int'($signed(off));
                if (jp)      m_pc = tgt % DEPTH;
                else if (br) m_pc = (m_pc + DEPTH + o) % DEPTH;
                else         m_pc = (m_pc + 1) % DEPTH;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 6'd0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectations mid-cycle.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            chk("inst_addr",   32'(bus.inst_addr),  32'(e.addr));
            chk("inst_valid",  32'(bus.inst_valid), 32'(e.valid));
            if (e.valid) chk("inst_out", 32'(bus.inst_out), 32'(e.inst));
            chk("done",        32'(bus.done),       32'(e.done));
            chk("timeout",     32'(bus.timeout),    32'(e.to));
            chk("cycle_count", bus.cycle_count,     e.cyc);
            chk("inst_count",  bus.inst_count,      e.icnt);
        end
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) rom[i] = 9'($urandom);
        Reset = 1'b1;
        bus.start = 0; bus.stall = 0; bus.halt_req = 0; bus.jump_en = 0;
        bus.jump_target = '0; bus.branch_en = 0; bus.branch_off = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;

        // Reset state and straight-line program halting at address 5.
        step(1, 0, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 0, 0, 0, 0, 0, 6'd0);
        plain(5);
        step(0, 0, 0, 1, 0, 0, 0, 6'd0);
        plain(3);

        // Backward branch, then negative branch from 0 wrapping to 1023 and back.
        step(0, 1, 0, 0, 0, 0, 0, 6'd0);
        plain(3);
        step(0, 0, 0, 0, 0, 0, 1, 6'b111110);
        step(0, 0, 0, 0, 1, 0, 0, 6'd0);
        step(0, 0, 0, 0, 0, 0, 1, 6'b111111);
        plain(1);

        // Jump wins over a simultaneous branch.
        plain(2);
        step(0, 0, 0, 0, 1, 40, 1, 6'd5);
        plain(1);
        step(0, 0, 0, 1, 0, 0, 0, 6'd0);
        plain(1);

        // Stall with halt pending for 3 cycles, then the halt is taken.
        step(0, 1, 0, 0, 0, 0, 0, 6'd0);
        plain(7);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0, 1, 6'd3);
        step(0, 0, 0, 1, 0, 0, 0, 6'd0);
        plain(2);

        // Infinite self-loop trips the watchdog; restart clears status.
        step(0, 1, 0, 0, 0, 0, 0, 6'd0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, m_pc, 0, 6'd0);
        step(0, 1, 0, 0, 0, 0, 0, 6'd0);
        plain(2);

        // start ignored in RUN; reset mid-RUN at pc 9 returns to IDLE.
        step(0, 1, 0, 0, 1, 0, 0, 6'd0);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0, 0, 0, 6'd0);
        step(1, 0, 0, 0, 0, 0, 0, 6'd0);
        plain(2);

        // Randomised control traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 100) == 0,
                 ($urandom % 10) == 0,
                 ($urandom % 5) == 0,
                 ($urandom % 30) == 0,
                 ($urandom % 10) == 0,
                 $urandom % DEPTH,
                 ($urandom % 6) == 0,
                 6'($urandom));
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
